// File: rtl/set_pulse_generator.sv
// rtl/set_pulse_generator.sv - debounced, auto-repeating decrement pulses for chess clock setting; optional macro SET_AUTOREPEAT_EN
module set_pulse_generator #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CE,
  input  logic BTN_UNITS,
  input  logic BTN_TENS,
  output logic US_DECREMENT_IMPULSE,
  output logic TS_DECREMENT_IMPULSE,
  output logic PRESSED
);

  // Channel 0 is units, channel 1 is tens; units wins on coincident requests.
  localparam int NCH  = 2;
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED
  } state_t;
`endif

  // Reject configurations the counters cannot represent at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("set_pulse_generator: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [NCH-1:0]  raw_btn;
  logic [NCH-1:0]  sync_meta;
  logic [NCH-1:0]  sync_lvl;
  logic [DB_W-1:0] db_cnt      [NCH];
  logic [DB_W-1:0] db_cnt_next [NCH];
  logic [NCH-1:0]  db_state;
  logic [NCH-1:0]  db_next;
  logic [NCH-1:0]  db_rise;
  state_t          state       [NCH];
  state_t          state_next  [NCH];
  logic [NCH-1:0]  req;
  logic            ts_pending;
`ifdef SET_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_cnt      [NCH];
  logic [RPT_W-1:0] rpt_cnt_next [NCH];
`endif

  assign raw_btn = {BTN_TENS, BTN_UNITS};

  // Two-flop synchroniser per button; runs regardless of CE.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      sync_meta <= '0;
      sync_lvl  <= '0;
    end else begin
      sync_meta <= raw_btn;
      sync_lvl  <= sync_meta;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip the accepted level on the last one.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      db_next[i]     = db_state[i];
      db_cnt_next[i] = '0;
      if (sync_lvl[i] != db_state[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          db_next[i] = sync_lvl[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // The FSM reacts to the edge being accepted now, so the first pulse lines up with the level change.
  assign db_rise = db_next & ~db_state;

  // Debounce state registers.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      db_state <= '0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_state <= db_next;
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

`ifdef SET_AUTOREPEAT_EN
  // Per-channel press/hold/repeat decisions; CE low parks everything in IDLE.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_next[i]   = state[i];
      rpt_cnt_next[i] = rpt_cnt[i];
      req[i]          = 1'b0;
      if (!CE) begin
        state_next[i]   = ST_IDLE;
        rpt_cnt_next[i] = '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            if (db_rise[i]) begin
              req[i]          = 1'b1;
              rpt_cnt_next[i] = DELAY_LOAD;
              state_next[i]   = ST_HOLD;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (!db_state[i]) begin
              state_next[i]   = ST_IDLE;
              rpt_cnt_next[i] = '0;
            end else if (rpt_cnt[i] == '0) begin
              req[i]          = 1'b1;
              rpt_cnt_next[i] = PERIOD_LOAD;
              state_next[i]   = ST_REPEAT;
            end else begin
              rpt_cnt_next[i] = rpt_cnt[i] - RPT_W'(1);
            end
          end
          default: begin
            state_next[i]   = ST_IDLE;
            rpt_cnt_next[i] = '0;
          end
        endcase
      end
    end
  end

  // FSM and repeat counter registers.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]   <= ST_IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]   <= state_next[i];
        rpt_cnt[i] <= rpt_cnt_next[i];
      end
    end
  end
`else
  // Per-channel single-shot decisions: one pulse per accepted press, re-armed by release.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_next[i] = state[i];
      req[i]        = 1'b0;
      if (!CE) begin
        state_next[i] = ST_IDLE;
      end else begin
        case (state[i])
          ST_IDLE: begin
            if (db_rise[i]) begin
              req[i]        = 1'b1;
              state_next[i] = ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (!db_state[i]) begin
              state_next[i] = ST_IDLE;
            end
          end
          default: state_next[i] = ST_IDLE;
        endcase
      end
    end
  end

  // FSM state registers.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_next[i];
      end
    end
  end
`endif

  // Registered outputs; a tens request colliding with units slips one cycle via ts_pending.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      US_DECREMENT_IMPULSE <= 1'b0;
      TS_DECREMENT_IMPULSE <= 1'b0;
      ts_pending           <= 1'b0;
      PRESSED              <= 1'b0;
    end else begin
      US_DECREMENT_IMPULSE <= req[0];
      TS_DECREMENT_IMPULSE <= CE & (ts_pending | (req[1] & ~req[0]));
      ts_pending           <= CE & req[1] & req[0];
      PRESSED              <= |db_next;
    end
  end

endmodule

// File: tb/tb_set_pulse_generator.sv
// tb/tb_set_pulse_generator.sv - randomized bench for set_pulse_generator against a timestamp-level reference model
module tb_set_pulse_generator;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic CLK = 1'b0;
  logic CLR;
  logic CE;
  logic BTN_UNITS;
  logic BTN_TENS;
  logic US_DECREMENT_IMPULSE;
  logic TS_DECREMENT_IMPULSE;
  logic PRESSED;

  always #5 CLK = ~CLK;

  set_pulse_generator #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK                 (CLK),
    .CLR                 (CLR),
    .CE                  (CE),
    .BTN_UNITS           (BTN_UNITS),
    .BTN_TENS            (BTN_TENS),
    .US_DECREMENT_IMPULSE(US_DECREMENT_IMPULSE),
    .TS_DECREMENT_IMPULSE(TS_DECREMENT_IMPULSE),
    .PRESSED             (PRESSED)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synchroniser as a 2-edge delay, debounce as a run of D disagreeing
  // samples, repeat timing as absolute edge timestamps.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_deb [2];
  bit m_armed [2];
  int m_run [2];
`ifdef SET_AUTOREPEAT_EN
  int m_fire [2];
`endif
  bit m_pend;
  bit m_us, m_ts, m_pr;
  int m_n = 0;

  task automatic model_edge(input bit clr, input bit ce, input bit bu, input bit bt);
    bit raw [2];
    bit rq [2];
    raw[0] = bu;
    raw[1] = bt;
    if (!clr) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_armed[c] = 0; m_run[c] = 0;
      end
      m_pend = 0; m_us = 0; m_ts = 0; m_pr = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit was;
        was = m_deb[c];
        if (m_s2[c] != m_deb[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_deb[c] = !m_deb[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
        rq[c] = 0;
        if (!ce) begin
          m_armed[c] = 0;
        end else if (!m_armed[c]) begin
          if (!was && m_deb[c]) begin
            rq[c] = 1;
            m_armed[c] = 1;
`ifdef SET_AUTOREPEAT_EN
            m_fire[c] = m_n + RD;
`endif
          end
        end else if (!was) begin
          m_armed[c] = 0;
        end
`ifdef SET_AUTOREPEAT_EN
        else if (m_n == m_fire[c]) begin
          rq[c] = 1;
          m_fire[c] = m_n + RP;
        end
`endif
      end
      m_us = rq[0];
      m_ts = ce && (m_pend || (rq[1] && !rq[0]));
      m_pend = rq[0] && rq[1];
      m_pr = m_deb[0] || m_deb[1];
    end
    m_n++;
  endtask

  int k, first_us, first_ts, n_us, n_ts;

  task automatic phase_start();
    k = 0; first_us = 0; first_ts = 0; n_us = 0; n_ts = 0;
  endtask

  task automatic step(input bit clr, input bit ce, input bit bu, input bit bt);
    CLR = clr; CE = ce; BTN_UNITS = bu; BTN_TENS = bt;
    @(posedge CLK);
    model_edge(clr, ce, bu, bt);
    @(negedge CLK);
    check_eq("us_pulse", int'(US_DECREMENT_IMPULSE), int'(m_us));
    check_eq("ts_pulse", int'(TS_DECREMENT_IMPULSE), int'(m_ts));
    check_eq("pressed", int'(PRESSED), int'(m_pr));
    k++;
    if (US_DECREMENT_IMPULSE) begin
      n_us++;
      if (first_us == 0) first_us = k;
    end
    if (TS_DECREMENT_IMPULSE) begin
      n_ts++;
      if (first_ts == 0) first_ts = k;
    end
  endtask

  task automatic hold(input bit ce, input bit bu, input bit bt, input int n);
    repeat (n) step(1'b1, ce, bu, bt);
  endtask

  initial begin
    bit bu, bt, ce, clr;
    int rate;
    CLR = 0; CE = 0; BTN_UNITS = 0; BTN_TENS = 0;
    repeat (3) step(0, 0, 0, 0);
    hold(1, 0, 0, 4);

    // Single debounced press on units.
    phase_start();
    hold(1, 1, 0, 8);
    hold(1, 0, 0, 12);
    check_eq("press_latency", first_us, D + 2);
    check_eq("press_count", n_us, 1);

    // Short glitch on tens is rejected.
    phase_start();
    hold(1, 0, 1, 3);
    hold(1, 0, 0, 10);
    check_eq("glitch_count", n_ts, 0);

    // Long hold: first pulse then auto-repeat (single pulse without the feature).
    phase_start();
    hold(1, 1, 0, 27);
    hold(1, 0, 0, 12);
    check_eq("hold_first", first_us, D + 2);
`ifdef SET_AUTOREPEAT_EN
    check_eq("hold_count", n_us, 7);
`else
    check_eq("hold_count", n_us, 1);
`endif

    // Coincident presses: tens deferred one cycle.
    phase_start();
    hold(1, 1, 1, 8);
    hold(1, 0, 0, 12);
    check_eq("coinc_us", first_us, D + 2);
    check_eq("coinc_ts", first_ts, D + 3);
    check_eq("coinc_ts_count", n_ts, 1);

    // Buttons already pressed when CE rises give nothing; re-press does.
    phase_start();
    hold(0, 1, 1, 20);
    hold(1, 1, 1, 10);
    check_eq("ce_gate_count", n_us + n_ts, 0);
    hold(1, 0, 0, 10);
    phase_start();
    hold(1, 1, 0, 8);
    check_eq("ce_repress", first_us, D + 2);
    hold(1, 0, 0, 12);

    // Reset in the middle of a held press.
    phase_start();
    hold(1, 1, 0, 10);
    step(0, 1, 1, 0);
    check_eq("reset_us", int'(US_DECREMENT_IMPULSE), 0);
    check_eq("reset_pressed", int'(PRESSED), 0);
    phase_start();
    hold(1, 1, 0, 10);
    check_eq("reset_repress", first_us, D + 2);
    hold(1, 0, 0, 12);

    // Randomized segments alternating bouncy and steady button activity.
    bu = 0; bt = 0; ce = 1; rate = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = ($urandom_range(0, 1) == 0) ? 3 : 40;
      if ($urandom_range(0, rate - 1) == 0) bu = !bu;
      if ($urandom_range(0, rate - 1) == 0) bt = !bt;
      if ($urandom_range(0, 79) == 0) ce = !ce;
      clr = ($urandom_range(0, 299) != 0);
      step(clr, ce, bu, bt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
